cdb_arbiter: RTL and testbench

//   Owns the Common Data Bus. Each functional unit (unit_ALU, MEM, MUL, DIV, JUMP) raises cdb_request

---
 rtl/cdb_arbiter_pkg.sv | 44 ++++
 rtl/cdb_rr_picker.sv | 31 +++
 rtl/cdb_arbiter.sv | 101 ++++++++++
 tb/tb_cdb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared Common Data Bus layout, functional-unit tags and requester indices.
// Everything that reads or writes a cdb word imports this package.
package cdb_arbiter_pkg;

    localparam int CDB_DATA_W   = 32;
    localparam int CDB_RS_W     = 6;
    localparam int CDB_FU_W     = 3;
    localparam int NUM_CDBBITS  = 1 + CDB_FU_W + CDB_RS_W + CDB_DATA_W;

    // Field positions are LSB indices inside the full cdb word.
    localparam int CDB_ON_FIELD = NUM_CDBBITS - 1;
    localparam int CDB_FU_FIELD = CDB_RS_W + CDB_DATA_W;
    localparam int CDB_RS_FIELD = CDB_DATA_W;

    localparam int CDB_NUM_REQ      = 5;
    localparam int CDB_STARVE_LIMIT = 4;

    localparam int CDB_REQ_ALU  = 0;
    localparam int CDB_REQ_MEM  = 1;
    localparam int CDB_REQ_MUL  = 2;
    localparam int CDB_REQ_DIV  = 3;
    localparam int CDB_REQ_JUMP = 4;

    typedef enum logic [CDB_FU_W-1:0] {
        FU_NONE_TAG = 3'd0,
        FU_ALU_TAG  = 3'd1,
        FU_MEM_TAG  = 3'd2,
        FU_MUL_TAG  = 3'd3,
        FU_DIV_TAG  = 3'd4,
        FU_JUMP_TAG = 3'd5
    } fu_tag_e;

    typedef struct packed {
        logic                  on;
        logic [CDB_FU_W-1:0]   fu;
        logic [CDB_RS_W-1:0]   rs;
        logic [CDB_DATA_W-1:0] data;
    } cdb_word_t;

    function automatic int wait_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational rotating-priority picker: first set bit of elig at or after ptr,
// wrapping at N-1. With ptr tied to zero it degenerates to lowest-index-first.
module cdb_rr_picker #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!valid && elig[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus owner: grants one functional unit per falling edge and drives the
// registered broadcast word. Round-robin with a starvation override; owner is masked.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = CDB_NUM_REQ,
    parameter int PAYLOAD_W    = NUM_CDBBITS - 1,
    parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
    output logic [PAYLOAD_W:0]             cdb,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           pending
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = wait_cnt_width(STARVE_LIMIT);

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   starving;
    logic [IDX_W-1:0]     rr_ptr;
    logic [WAIT_W-1:0]    wait_cnt [NUM_REQ];

    logic [NUM_REQ-1:0]   starve_onehot;
    logic [IDX_W-1:0]     starve_idx;
    logic                 starve_valid;
    logic [NUM_REQ-1:0]   rr_onehot;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_valid;

    logic [NUM_REQ-1:0]   sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;
    logic [PAYLOAD_W-1:0] sel_payload;

    // The owner still holds req on the edge it first sees its own tag; mask it.
    assign elig    = req & ~grant;
    assign pending = |elig;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_starve
        assign starving[i] = elig[i] & (wait_cnt[i] == WAIT_W'(STARVE_LIMIT));
    end

    cdb_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_starve_pick (
        .elig  (starving),
        .ptr   ('0),
        .grant (starve_onehot),
        .idx   (starve_idx),
        .valid (starve_valid)
    );

    cdb_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (rr_onehot),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    assign sel_valid   = rr_valid;
    assign sel_onehot  = starve_valid ? starve_onehot : rr_onehot;
    assign sel_idx     = starve_valid ? starve_idx    : rr_idx;
    assign sel_payload = req_payload[int'(sel_idx)*PAYLOAD_W +: PAYLOAD_W];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cdb    <= '0;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            cdb    <= '0;
            grant  <= '0;
        end else if (sel_valid) begin
            cdb    <= {1'b1, sel_payload};
            grant  <= sel_onehot;
            rr_ptr <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end else begin
            cdb    <= '0;
            grant  <= '0;
        end
    end

    // Waiting time counts only while a unit keeps asking and is not served.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush || !req[i] || (sel_valid && sel_onehot[i]))
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WAIT_W'(STARVE_LIMIT))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a loop-based reference model checked every cycle.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N   = CDB_NUM_REQ;
    localparam int PW  = NUM_CDBBITS - 1;
    localparam int LIM = CDB_STARVE_LIMIT;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [N-1:0]      req;
    logic [N*PW-1:0]   req_payload;
    logic [PW:0]       cdb;
    logic [N-1:0]      grant;
    logic              pending;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [PW:0] m_cdb;
    int          m_gidx;
    int          m_rr;
    int          m_wait [N];

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req         (req),
        .req_payload (req_payload),
        .cdb         (cdb),
        .grant       (grant),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int i, input logic [31:0] d);
        cdb_word_t w;
        w.on   = 1'b0;
        w.fu   = 3'(i + 1);
        w.rs   = 6'(1 << i);
        w.data = d;
        return w[PW-1:0];
    endfunction

    task automatic set_pl(input int i, input logic [31:0] d);
        req_payload[i*PW +: PW] = mk(i, d);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: served at the falling edge from the rules, with plain loops and modulo.
    always @(negedge clk or posedge rst) begin : model
        int sel;
        logic [N-1:0] el;
        if (rst) begin
            m_cdb = '0; m_gidx = -1; m_rr = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else if (flush) begin
            m_cdb = '0; m_gidx = -1;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            sel = -1;
            for (int i = 0; i < N; i++) el[i] = req[i] && (m_gidx != i);
            for (int i = 0; i < N; i++)
                if (sel < 0 && el[i] && m_wait[i] == LIM) sel = i;
            for (int k = 0; k < N; k++)
                if (sel < 0 && el[(m_rr + k) % N]) sel = (m_rr + k) % N;
            for (int i = 0; i < N; i++)
                m_wait[i] = (i == sel || !req[i]) ? 0 : ((m_wait[i] < LIM) ? m_wait[i] + 1 : LIM);
            if (sel >= 0) begin
                m_cdb  = {1'b1, req_payload[sel*PW +: PW]};
                m_gidx = sel;
                m_rr   = (sel + 1) % N;
            end else begin
                m_cdb  = '0;
                m_gidx = -1;
            end
        end
    end

    always @(posedge clk) begin : compare
        logic [N-1:0] eg;
        if (chk_en && !rst) begin
            eg = (m_gidx < 0) ? '0 : N'(1 << m_gidx);
            check("model_cdb", 64'(cdb), 64'(m_cdb));
            check("model_grant", 64'(grant), 64'(eg));
            check("model_pending", 64'(pending), 64'(|(req & ~eg)));
        end
    end

    initial begin
        logic [N-1:0] seen_prev;
        int order [$];
        int n;
        bit got;

        rst = 1'b1; flush = 1'b0; req = '0; req_payload = '0;
        for (int i = 0; i < N; i++) set_pl(i, 32'h100 + i);
        chk_en = 1'b1;
        step();
        check("reset_cdb", 64'(cdb), 64'h0);
        check("reset_grant", 64'(grant), 64'h0);
        step();
        rst = 1'b0;

        // 1: async reset in the middle of a broadcast
        req = '1;
        step();
        check("t1_first_grant", 64'(grant), 64'h1);
        check("t1_first_cdb", 64'(cdb), {22'h0, 1'b1, 3'd1, 6'b000001, 32'h100});
        rst = 1'b1;
        #1;
        check("t1_async_cdb", 64'(cdb), 64'h0);
        check("t1_async_grant", 64'(grant), 64'h0);
        step();
        rst = 1'b0;
        step();
        check("t1_after_rst", 64'(grant), 64'h1);
        req = '0;
        step();

        // 2: single requester, owner masking and payload capture
        rst = 1'b1; step(); rst = 1'b0;
        set_pl(0, 32'h1234);
        req = 5'b00001;
        step();
        check("t2_grant", 64'(grant), 64'h1);
        check("t2_data", 64'(cdb[31:0]), 64'h1234);
        check("t2_on", 64'(cdb[CDB_ON_FIELD]), 64'h1);
        set_pl(0, 32'hdead);
        #1;
        check("t2_hold", 64'(cdb[31:0]), 64'h1234);
        step();
        check("t2_masked", 64'(grant), 64'h0);
        check("t2_masked_cdb", 64'(cdb), 64'h0);
        step();
        check("t2_regrant", 64'(grant), 64'h1);
        check("t2_new_data", 64'(cdb[31:0]), 64'hdead);
        req = '0;
        step();

        // 3: round-robin over all five, each unit drops req one edge after its grant
        rst = 1'b1; step(); rst = 1'b0;
        req = '1;
        seen_prev = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            for (int i = 0; i < N; i++) if (seen_prev[i]) req[i] = 1'b0;
            seen_prev = grant;
            for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
        end
        check("t3_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size() && i < 5; i++) check("t3_order", 64'(order[i]), 64'(i));
        req = 5'b00001;
        step();
        check("t3_wrap", 64'(grant), 64'h1);
        req = '0;
        step();

        // 5: flush collides with requests; rr_ptr is 1 here
        req = 5'b00110; flush = 1'b1;
        step();
        check("t5_flush_cdb", 64'(cdb), 64'h0);
        check("t5_flush_grant", 64'(grant), 64'h0);
        flush = 1'b0;
        step();
        check("t5_after", 64'(grant), 64'h2);
        req = '0;
        step();

        // 4: ALU and MEM toggle-feed while JUMP waits
        got = 1'b0; n = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            req[0] = (k % 2 == 0);
            req[1] = (k % 2 == 1);
            req[4] = 1'b1;
            step();
            if (grant[4]) begin got = 1'b1; n = k + 1; end
        end
        check("t4_jump_served", 64'(got && n <= LIM + 1), 64'h1);
        req = '0;
        step();

        // 6: idle bus
        for (int k = 0; k < 10; k++) begin
            step();
            check("t6_idle", 64'({cdb, grant, pending}), 64'h0);
        end
        req = '1;
        repeat (6) step();
        req = '0;
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
